// File: rtl/sdc_init_ctrl.sv
// rtl/sdc_init_ctrl.sv - SD-card SPI-mode initialisation sequencer (CMD0, CMD8, CMD55/ACMD41)
module sdc_init_ctrl #(
  parameter int NCR_MAX    = 8,
  parameter int ACMD41_MAX = 255,
  parameter int GAP_BYTES  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_dummy_start,
  input  logic       i_dummy_done,
  output logic       o_spi_start,
  output logic [7:0] o_spi_tx,
  input  logic [7:0] i_spi_rx,
  input  logic       i_spi_done,
  output logic       o_cs,
  output logic       o_busy,
  output logic       o_ready,
  output logic       o_error,
  output logic [2:0] o_err_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_DUMMY, S_CMD, S_POLL, S_EVAL, S_TAIL, S_LINK, S_GAP, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0] C_CMD0   = 2'd0;
  localparam logic [1:0] C_CMD8   = 2'd1;
  localparam logic [1:0] C_CMD55  = 2'd2;
  localparam logic [1:0] C_ACMD41 = 2'd3;

  localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_BYTES - 1);
  localparam logic [7:0] ACMD_LIM = 8'(ACMD41_MAX);

  state_t     state_q, state_d;
  logic [1:0] cmd_q, cmd_d;
  logic [1:0] next_q, next_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] iter_q, iter_d;
  logic [7:0] r1_q, r1_d;
  logic       pend_q, pend_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       error_q, error_d;
  logic [2:0] code_q, code_d;
  logic       cs_q, cs_d;

  logic       xfer;
  logic       done;
  logic       fail;
  logic [2:0] fail_code;
  logic [7:0] tx;
  logic [7:0] iter_inc;

  // Six-byte command frames, CRC included (only CMD0/CMD8 CRCs matter in SPI mode)
  function automatic logic [7:0] frame_byte(input logic [1:0] cmd, input logic [2:0] idx);
    logic [47:0] f;
    case (cmd)
      C_CMD0:  f = 48'h40_00_00_00_00_95;
      C_CMD8:  f = 48'h48_00_00_01_AA_87;
      C_CMD55: f = 48'h77_00_00_00_00_01;
      default: f = 48'h69_40_00_00_00_01;
    endcase
    case (idx)
      3'd0:    frame_byte = f[47:40];
      3'd1:    frame_byte = f[39:32];
      3'd2:    frame_byte = f[31:24];
      3'd3:    frame_byte = f[23:16];
      3'd4:    frame_byte = f[15:8];
      default: frame_byte = f[7:0];
    endcase
  endfunction

  // Next-state, byte-issue handshake and status updates
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    next_d    = next_q;
    cnt_d     = cnt_q;
    iter_d    = iter_q;
    r1_d      = r1_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    error_d   = error_q;
    code_d    = code_q;
    o_dummy_start = 1'b0;
    o_spi_start   = 1'b0;
    tx        = 8'hFF;
    xfer      = 1'b0;
    fail      = 1'b0;
    fail_code = 3'd0;
    done      = i_spi_done & pend_q;
    iter_inc  = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          ready_d = 1'b0;
          error_d = 1'b0;
          code_d  = 3'd0;
          busy_d  = 1'b1;
          o_dummy_start = 1'b1;
          cmd_d   = C_CMD0;
          iter_d  = 8'd0;
          cnt_d   = 8'd0;
          state_d = S_DUMMY;
        end
      end
      S_DUMMY: begin
        if (i_dummy_done) begin
          state_d = S_CMD;
          cnt_d   = 8'd0;
        end
      end
      S_CMD: begin
        xfer = 1'b1;
        tx   = frame_byte(cmd_q, cnt_q[2:0]);
        if (done) begin
          if (cnt_q == 8'd5) begin
            state_d = S_POLL;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_POLL: begin
        xfer = 1'b1;
        if (done) begin
          if (!i_spi_rx[7]) begin
            r1_d    = i_spi_rx;
            state_d = S_EVAL;
          end else if (cnt_q == NCR_LAST) begin
            fail      = 1'b1;
            fail_code = 3'd4;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_EVAL: begin
        cnt_d = 8'd0;
        case (cmd_q)
          C_CMD0: begin
            if (r1_q == 8'h01) begin
              state_d = S_GAP;
              next_d  = C_CMD8;
            end else begin
              fail = 1'b1; fail_code = 3'd1;
            end
          end
          C_CMD8: begin
            if (r1_q == 8'h01) state_d = S_TAIL;
            else begin
              fail = 1'b1; fail_code = 3'd2;
            end
          end
          C_CMD55: begin
            if (r1_q[7:1] == 7'd0) state_d = S_LINK;
            else begin
              fail = 1'b1; fail_code = 3'd3;
            end
          end
          default: begin
            if (r1_q == 8'h00) begin
              state_d = S_DONE;
            end else if (r1_q == 8'h01) begin
              iter_d = iter_inc;
              if (iter_inc == ACMD_LIM) begin
                fail = 1'b1; fail_code = 3'd3;
              end else begin
                state_d = S_GAP;
                next_d  = C_CMD55;
              end
            end else begin
              fail = 1'b1; fail_code = 3'd3;
            end
          end
        endcase
      end
      S_TAIL: begin
        xfer = 1'b1;
        if (done) begin
          if (cnt_q == 8'd3) begin
            if (i_spi_rx == 8'hAA) begin
              state_d = S_GAP;
              next_d  = C_CMD55;
              cnt_d   = 8'd0;
            end else begin
              fail = 1'b1; fail_code = 3'd2;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_LINK: begin
        // one 0xFF with CS still asserted between CMD55 and ACMD41
        xfer = 1'b1;
        if (done) begin
          state_d = S_CMD;
          cmd_d   = C_ACMD41;
          cnt_d   = 8'd0;
        end
      end
      S_GAP: begin
        xfer = 1'b1;
        if (done) begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_CMD;
            cmd_d   = next_q;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        xfer = 1'b1;
        if (done) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // only one byte in flight; a new start waits for the cycle after done
    if (xfer && !pend_q) begin
      o_spi_start = 1'b1;
      pend_d      = 1'b1;
    end
    if (done) pend_d = 1'b0;

    if (fail) begin
      state_d = S_ERR;
      error_d = 1'b1;
      code_d  = fail_code;
      busy_d  = 1'b0;
      cnt_d   = 8'd0;
    end

    cs_d = !(state_d inside {S_CMD, S_POLL, S_EVAL, S_TAIL, S_LINK});
  end

  // State and status registers; reset aborts any sequence at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= C_CMD0;
      next_q  <= C_CMD0;
      cnt_q   <= 8'd0;
      iter_q  <= 8'd0;
      r1_q    <= 8'd0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      code_q  <= 3'd0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      next_q  <= next_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      r1_q    <= r1_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      error_q <= error_d;
      code_q  <= code_d;
      cs_q    <= cs_d;
    end
  end

  assign o_spi_tx   = tx;
  assign o_cs       = cs_q;
  assign o_busy     = busy_q;
  assign o_ready    = ready_q;
  assign o_error    = error_q;
  assign o_err_code = code_q;

endmodule

// File: tb/tb_sdc_init_ctrl.sv
// tb/tb_sdc_init_ctrl.sv - directed bench for sdc_init_ctrl with an SPI/SD-card responder
module tb_sdc_init_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic       o_dummy_start;
  logic       i_dummy_done;
  logic       o_spi_start;
  logic [7:0] o_spi_tx;
  logic [7:0] i_spi_rx;
  logic       i_spi_done;
  logic       o_cs;
  logic       o_busy;
  logic       o_ready;
  logic       o_error;
  logic [2:0] o_err_code;

  int total = 0;
  int bad   = 0;

  // card/engine model state
  int         dly = 0;
  int         dcnt = 0;
  int         fidx = 0;
  logic [5:0] cur = 6'd0;
  logic [7:0] rx_next = 8'hFF;
  logic [7:0] q[$];
  int n0 = 0, n8 = 0, n55 = 0, n41 = 0, nbytes = 0, proto = 0;

  // card behaviour knobs
  logic [7:0] r1_c0 = 8'h01;
  logic [7:0] echo_c8 = 8'hAA;
  bit         silent0 = 1'b0;
  int         a41_ok_on = 3;

  always #5 clk = ~clk;

  sdc_init_ctrl #(.NCR_MAX(8), .ACMD41_MAX(4), .GAP_BYTES(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .o_dummy_start(o_dummy_start), .i_dummy_done(i_dummy_done),
    .o_spi_start(o_spi_start), .o_spi_tx(o_spi_tx), .i_spi_rx(i_spi_rx),
    .i_spi_done(i_spi_done), .o_cs(o_cs), .o_busy(o_busy), .o_ready(o_ready),
    .o_error(o_error), .o_err_code(o_err_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic card_byte(input logic [7:0] tx);
    if (!o_cs && fidx == 0 && tx[7:6] == 2'b01) begin
      cur = tx[5:0];
      fidx = 1;
      rx_next = 8'hFF;
      q.delete();
      case (cur)
        6'd0:  n0++;
        6'd8:  n8++;
        6'd55: n55++;
        6'd41: n41++;
        default: ;
      endcase
    end else if (fidx > 0) begin
      rx_next = 8'hFF;
      fidx++;
      if (fidx == 6) begin
        fidx = 0;
        case (cur)
          6'd0: if (!silent0) begin q.push_back(8'hFF); q.push_back(r1_c0); end
          6'd8: begin
            q.push_back(8'hFF); q.push_back(8'h01); q.push_back(8'h00);
            q.push_back(8'h00); q.push_back(8'h01); q.push_back(echo_c8);
          end
          6'd55: begin q.push_back(8'hFF); q.push_back(8'h01); end
          6'd41: begin
            q.push_back(8'hFF);
            q.push_back((a41_ok_on != 0 && n41 == a41_ok_on) ? 8'h00 : 8'h01);
          end
          default: ;
        endcase
      end
    end else begin
      rx_next = (q.size() > 0) ? q.pop_front() : 8'hFF;
    end
  endtask

  // Dummy-clock generator and byte engine: done arrives two cycles after start
  always @(negedge clk) begin
    if (!rst_n) begin
      dly = 0; dcnt = 0; fidx = 0; q.delete();
      i_spi_done = 1'b0; i_dummy_done = 1'b0;
    end else begin
      i_spi_done = 1'b0;
      i_dummy_done = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) i_dummy_done = 1'b1;
      end else if (o_dummy_start) begin
        dcnt = 10;
      end
      if (dly > 0) begin
        if (o_spi_start) proto++;
        dly--;
        if (dly == 0) begin
          i_spi_done = 1'b1;
          i_spi_rx = rx_next;
        end
      end else if (o_spi_start) begin
        nbytes++;
        card_byte(o_spi_tx);
        dly = 2;
      end
    end
  end

  task automatic clr_counts();
    n0 = 0; n8 = 0; n55 = 0; n41 = 0; nbytes = 0;
  endtask

  task automatic do_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!(o_ready || o_error) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(o_ready || o_error), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k;
    int snap;
    rst_n = 1'b0; i_start = 1'b0; i_spi_rx = 8'hFF;
    i_spi_done = 1'b0; i_dummy_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(o_cs), 32'd1);
    chk("rst_tx", 32'(o_spi_tx), 32'hFF);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_code", 32'(o_err_code), 32'd0);
    chk("rst_spi_start", 32'(o_spi_start), 32'd0);
    chk("rst_dummy_start", 32'(o_dummy_start), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // nominal card: ACMD41 ready on third try
    clr_counts();
    do_start();
    chk("nom_busy", 32'(o_busy), 32'd1);
    wait_end("nom_timeout");
    chk("nom_ready", 32'(o_ready), 32'd1);
    chk("nom_error", 32'(o_error), 32'd0);
    chk("nom_code", 32'(o_err_code), 32'd0);
    chk("nom_cs", 32'(o_cs), 32'd1);
    chk("nom_busy_end", 32'(o_busy), 32'd0);
    chk("nom_n55", 32'(n55), 32'd3);
    chk("nom_n41", 32'(n41), 32'd3);
    chk("nom_bytes", 32'(nbytes), 32'd76);

    // CMD0 bad R1
    clr_counts(); r1_c0 = 8'h05;
    do_start();
    wait_end("c0_timeout");
    chk("c0_error", 32'(o_error), 32'd1);
    chk("c0_ready", 32'(o_ready), 32'd0);
    chk("c0_code", 32'(o_err_code), 32'd1);
    chk("c0_no_cmd8", 32'(n8), 32'd0);
    r1_c0 = 8'h01;

    // silent card on CMD0: 6 frame bytes + NCR_MAX polls
    clr_counts(); silent0 = 1'b1;
    do_start();
    wait_end("ncr_timeout");
    chk("ncr_code", 32'(o_err_code), 32'd4);
    chk("ncr_bytes", 32'(nbytes), 32'd14);
    chk("ncr_cs", 32'(o_cs), 32'd1);
    silent0 = 1'b0;

    // bad CMD8 echo
    clr_counts(); echo_c8 = 8'hAB;
    do_start();
    wait_end("echo_timeout");
    chk("echo_error", 32'(o_error), 32'd1);
    chk("echo_code", 32'(o_err_code), 32'd2);
    echo_c8 = 8'hAA;

    // ACMD41 never ready, limit 4
    clr_counts(); a41_ok_on = 0;
    do_start();
    wait_end("a41_timeout");
    chk("a41_code", 32'(o_err_code), 32'd3);
    chk("a41_frames", 32'(n41), 32'd4);
    chk("a41_ready", 32'(o_ready), 32'd0);
    a41_ok_on = 3;

    // reset during CMD8 frame
    clr_counts();
    do_start();
    k = 0;
    while (n8 == 0 && k < 1000) begin @(negedge clk); k++; end
    chk("mid_reached_cmd8", 32'(n8), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_cs", 32'(o_cs), 32'd1);
    chk("mid_busy", 32'(o_busy), 32'd0);
    snap = nbytes;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_more_bytes", 32'(nbytes), 32'(snap));
    chk("mid_idle_busy", 32'(o_busy), 32'd0);

    // restart, with a stray i_start partway through
    clr_counts();
    do_start();
    repeat (40) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_end("re_timeout");
    chk("re_ready", 32'(o_ready), 32'd1);
    chk("re_n0", 32'(n0), 32'd1);
    chk("re_bytes", 32'(nbytes), 32'd76);
    chk("re_n55", 32'(n55), 32'd3);
    chk("proto_one_outstanding", 32'(proto), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdc_init_ctrl.md
Name: sdc_init_ctrl

Overview:
SD-card SPI-mode initialisation sequencer.
- On i_start, triggers the power-up dummy-clock generator and waits for it to finish.
- Then issues CMD0, CMD8, and the CMD55/ACMD41 loop through the byte-level SPI engine, checking each R1/R7 response.
- Reports o_ready on success or o_error with a code. Sits between the top-level FSM and the dummy-clock/SPI byte engines.

Parameters:
NCR_MAX, 8, response-poll byte limit per command (bytes of 0xFF tolerated before timeout)
ACMD41_MAX, 255, maximum CMD55/ACMD41 iterations before init timeout
GAP_BYTES, 1, 0xFF bytes clocked with CS high between commands

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  start init; sampled only in IDLE
o_dummy_start  output  1  one-cycle pulse to the dummy-clock generator
i_dummy_done  input  1  one-cycle pulse: dummy clocks complete
o_spi_start  output  1  one-cycle pulse: transfer o_spi_tx
o_spi_tx  output  8  byte to send; held stable until i_spi_done
i_spi_rx  input  8  received byte; valid in the cycle i_spi_done=1
i_spi_done  input  1  one-cycle pulse: byte transfer complete
o_cs  output  1  SD chip select, active low
o_busy  output  1  sequence in progress
o_ready  output  1  card initialised (sticky until next i_start or reset)
o_error  output  1  init failed (sticky until next i_start or reset)
o_err_code  output  3  1=CMD0 bad R1, 2=CMD8 bad R1/echo, 3=ACMD41 timeout, 4=NCR timeout, 0=none

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_cs=1, o_spi_tx=8'hFF, all other outputs 0, counters 0. Reset mid-sequence aborts immediately; no further SPI pulses.
- One outstanding SPI byte at a time: o_spi_start only when no transfer is pending; the next pulse comes no earlier than the cycle after i_spi_done.
- IDLE: i_start=1 clears o_ready/o_error/o_err_code, sets o_busy, pulses o_dummy_start, goes to DUMMY. i_start in any other state is ignored.
- DUMMY: o_cs=1; wait for i_dummy_done, then go to CMD.
- CMD: o_cs=0; send 6 bytes from a frame selected by the command index:
  - CMD0 = 40 00 00 00 00 95
  - CMD8 = 48 00 00 01 AA 87
  - CMD55 = 77 00 00 00 00 01
  - ACMD41 = 69 40 00 00 00 01
  Byte counter 0..5; after the 6th i_spi_done, go to POLL.
- POLL: send 0xFF repeatedly. The first rx byte with bit7=0 is R1 → EVAL. If NCR_MAX bytes all have bit7=1 → ERR, code 4.
- EVAL:
  - CMD0: R1==0x01 → GAP then CMD8; else ERR code 1.
  - CMD8: R1==0x01 → TAIL (4 more 0xFF bytes; the 4th rx must equal 0xAA, else ERR code 2); else ERR code 2.
  - CMD55: any R1 with bit7=0 and bits[6:1]=0 → ACMD41 immediately with CS still low after one gap byte; else ERR code 3.
  - ACMD41: R1==0x00 → DONE. R1==0x01 → increment iteration count; if count==ACMD41_MAX → ERR code 3, else GAP then CMD55. Other value → ERR code 3.
- GAP: o_cs=1, send GAP_BYTES of 0xFF, then the next command.
- DONE: o_cs=1, send one 0xFF byte, then set o_ready=1, o_busy=0, return to IDLE.
- ERR: o_cs=1 in the next cycle, o_error=1, o_err_code latched, o_busy=0, return to IDLE.
- o_ready and o_error are never both 1. The iteration counter is 8 bits and saturates; there is no wrap.

Test Plan:
- Nominal card: dummy_done after 10 cycles; responses CMD0→01, CMD8→01 00 00 01 AA, ACMD41→01 then 00 on 3rd try → o_ready=1, o_err_code=0, exactly 3 CMD55 frames observed, o_cs=1 at end.
- CMD0 returns 0x05 → o_error=1, o_err_code=1, no CMD8 byte 0x48 ever sent.
- Card silent (rx always 0xFF) on CMD0 → exactly 8 poll bytes after the frame, then o_err_code=4, o_cs=1.
- CMD8 echo byte 0xAB instead of 0xAA → o_err_code=2.
- ACMD41 always returns 0x01 with ACMD41_MAX=4 → 4 ACMD41 frames, then o_err_code=3.
- Assert i_rst_n low during the CMD8 frame → o_cs=1 and o_busy=0 immediately, no further o_spi_start; re-start completes normally; i_start pulsed mid-sequence has no effect.
